// File: rtl/ddr_pad_receiver.sv
// Dance-pad input receiver: per-pad 2-flop sync, counter debounce, edge strobes, event FIFO.
// Optional release events are enabled with `define PAD_RELEASE_EVT_EN.
module ddr_pad_receiver #(
    parameter int N_PADS          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PADS-1:0] pad_raw,
    output logic [N_PADS-1:0] pad_state,
    output logic [N_PADS-1:0] press_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [N_PADS-1:0] evt_press,
    output logic [N_PADS-1:0] evt_release,
    output logic              evt_overflow,
    input  logic              clr_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
`ifdef PAD_RELEASE_EVT_EN
    localparam int ENT_W = 2 * N_PADS;
`else
    localparam int ENT_W = N_PADS;
`endif

    logic [N_PADS-1:0] r_sync_p0;
    logic [N_PADS-1:0] r_sync_p1;
    logic [N_PADS-1:0] r_stable;
    logic [N_PADS-1:0] r_press;
    logic [CNT_W-1:0]  r_cnt [N_PADS];
    logic [N_PADS-1:0] w_flip;
    logic [N_PADS-1:0] w_rise;

    // Strobes are computed from the flip condition so they land in the same cycle as pad_state.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < N_PADS; i++) begin
            w_flip[i] = (r_sync_p1[i] != r_stable[i]) && (r_cnt[i] == DB_LAST);
        end
        w_rise = w_flip & r_sync_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_stable  <= '0;
            r_press   <= '0;
            for (int i = 0; i < N_PADS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync_p0 <= pad_raw;
            r_sync_p1 <= r_sync_p0;
            r_press   <= w_rise;
            for (int i = 0; i < N_PADS; i++) begin
                if (r_sync_p1[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync_p1[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pad_state   = r_stable;
    assign press_pulse = r_press;

    logic             w_push;
    logic [ENT_W-1:0] w_entry;

`ifdef PAD_RELEASE_EVT_EN
    logic [N_PADS-1:0] r_release;
    logic [N_PADS-1:0] w_fall;

    assign w_fall = w_flip & ~r_sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_release <= '0;
        end else begin
            r_release <= w_fall;
        end
    end

    assign w_push  = (|r_press) | (|r_release);
    assign w_entry = {r_release, r_press};
`else
    assign w_push  = |r_press;
    assign w_entry = r_press;
`endif

    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_overflow;
    logic              w_full;
    logic              w_pop;
    logic              w_do_push;
    logic [ENT_W-1:0]  w_head;

    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == FIFO_FULL);
    assign w_pop     = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_pop) begin
                r_count <= r_count + FCNT_W'(1);
            end else if (!w_do_push && w_pop) begin
                r_count <= r_count - FCNT_W'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Head is masked by evt_valid so an empty or reset FIFO presents zeros.
    assign w_head       = evt_valid ? r_mem[r_rd_ptr] : '0;
    assign evt_press    = w_head[N_PADS-1:0];
    assign evt_overflow = r_overflow;
`ifdef PAD_RELEASE_EVT_EN
    assign evt_release  = w_head[ENT_W-1:N_PADS];
`else
    assign evt_release  = '0;
`endif

endmodule

// File: tb/tb_ddr_pad_receiver.sv
// Directed bench for ddr_pad_receiver with DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
module tb_ddr_pad_receiver;

    logic       clk;
    logic       rst;
    logic [3:0] pad_raw;
    logic [3:0] pad_state;
    logic [3:0] press_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_press;
    logic [3:0] evt_release;
    logic       evt_overflow;
    logic       clr_overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

`ifdef PAD_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    ddr_pad_receiver #(
        .N_PADS          (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pad_raw      (pad_raw),
        .pad_state    (pad_state),
        .press_pulse  (press_pulse),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_press    (evt_press),
        .evt_release  (evt_release),
        .evt_overflow (evt_overflow),
        .clr_overflow (clr_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a new raw level and run to just after the FIFO push edge.
    task automatic pad_event(input logic [3:0] raw, input bit pop_at_push);
        pad_raw = raw;
        repeat (6) tick();
        if (pop_at_push) evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    logic [3:0] exp_p [4];
    logic [3:0] exp_r [4];
    logic [3:0] exp_head;
    logic       seen_pulse;

    initial begin
        rst          = 1'b1;
        pad_raw      = 4'b0000;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
`ifdef PAD_RELEASE_EVT_EN
        exp_p[0] = 4'b1000; exp_p[1] = 4'b0000; exp_p[2] = 4'b0000; exp_p[3] = 4'b0001;
        exp_r[0] = 4'b0000; exp_r[1] = 4'b0001; exp_r[2] = 4'b0001; exp_r[3] = 4'b0000;
        exp_head = 4'b0010;
`else
        exp_p[0] = 4'b0010; exp_p[1] = 4'b0100; exp_p[2] = 4'b1000; exp_p[3] = 4'b0001;
        exp_r[0] = 4'b0000; exp_r[1] = 4'b0000; exp_r[2] = 4'b0000; exp_r[3] = 4'b0000;
        exp_head = 4'b0001;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_pad_state", pad_state, 4'b0000);
        chk("rst_press_pulse", press_pulse, 4'b0000);
        chk("rst_evt_valid", evt_valid, 1'b0);
        chk("rst_evt_press", evt_press, 4'b0000);
        chk("rst_evt_release", evt_release, 4'b0000);
        chk("rst_overflow", evt_overflow, 1'b0);
        rst = 1'b0;

        // Clean press on pad 0
        pad_raw = 4'b0001;
        repeat (5) tick();
        chk("clean_state_early", pad_state, 4'b0000);
        chk("clean_pulse_early", press_pulse, 4'b0000);
        tick();
        chk("clean_state", pad_state, 4'b0001);
        chk("clean_pulse", press_pulse, 4'b0001);
        chk("clean_valid_early", evt_valid, 1'b0);
        tick();
        chk("clean_pulse_one_cycle", press_pulse, 4'b0000);
        chk("clean_valid", evt_valid, 1'b1);
        chk("clean_evt_press", evt_press, 4'b0001);
        chk("clean_evt_release", evt_release, 4'b0000);
        tick();
        chk("clean_hold_valid", evt_valid, 1'b1);
        chk("clean_hold_press", evt_press, 4'b0001);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("clean_pop_valid", evt_valid, 1'b0);

        // Bounce on pad 2: toggle every 2 cycles for 20 cycles
        seen_pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pad_raw[2] = ~pad_raw[2];
            repeat (2) begin
                tick();
                if (press_pulse != 4'b0000) seen_pulse = 1'b1;
            end
        end
        chk("bounce_no_pulse", seen_pulse, 1'b0);
        chk("bounce_state", pad_state, 4'b0001);
        chk("bounce_no_entry", evt_valid, 1'b0);
        pad_raw = 4'b0101;
        repeat (5) tick();
        chk("bounce_pulse_early", press_pulse, 4'b0000);
        tick();
        chk("bounce_pulse", press_pulse, 4'b0100);
        tick();
        chk("bounce_valid", evt_valid, 1'b1);
        chk("bounce_evt_press", evt_press, 4'b0100);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("bounce_single_entry", evt_valid, 1'b0);

        // Simultaneous presses on pads 1 and 3
        pad_raw = 4'b1111;
        repeat (6) tick();
        chk("simul_pulse", press_pulse, 4'b1010);
        chk("simul_state", pad_state, 4'b1111);
        tick();
        chk("simul_pulse_off", press_pulse, 4'b0000);
        chk("simul_evt_press", evt_press, 4'b1010);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("simul_single_entry", evt_valid, 1'b0);

        // Overflow: fill with four presses, then a dropped fifth press
        pad_raw = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        pad_event(4'b0001, 1'b0);
        pad_event(4'b0011, 1'b0);
        pad_event(4'b0111, 1'b0);
        pad_event(4'b1111, 1'b0);
        chk("full_valid", evt_valid, 1'b1);
        chk("full_head", evt_press, 4'b0001);
        chk("full_no_overflow", evt_overflow, 1'b0);
        pad_event(4'b1110, REL_EN);
        chk("full_release_no_overflow", evt_overflow, 1'b0);
        pad_event(4'b1111, 1'b0);
        chk("overflow_set", evt_overflow, 1'b1);
        chk("overflow_head_kept", evt_press, exp_head);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("overflow_cleared", evt_overflow, 1'b0);
        pad_event(4'b1110, REL_EN);
        pad_event(4'b1111, 1'b1);
        chk("full_pushpop_no_overflow", evt_overflow, 1'b0);
        chk("full_pushpop_valid", evt_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), evt_valid, 1'b1);
            chk($sformatf("drain%0d_press", i), evt_press, exp_p[i]);
            chk($sformatf("drain%0d_release", i), evt_release, exp_r[i]);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        chk("drain_empty", evt_valid, 1'b0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("empty_pop_ignored", evt_valid, 1'b0);

        // Reset mid-count with entries queued
        pad_event(4'b0000, 1'b0);
        pad_event(4'b0001, 1'b0);
        pad_event(4'b0011, 1'b0);
        chk("pre_reset_valid", evt_valid, 1'b1);
        pad_raw = 4'b0111;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", pad_state, 4'b0000);
        chk("async_rst_pulse", press_pulse, 4'b0000);
        chk("async_rst_valid", evt_valid, 1'b0);
        chk("async_rst_press", evt_press, 4'b0000);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_state_early", pad_state, 4'b0000);
        chk("post_rst_no_stale", evt_valid, 1'b0);
        tick();
        chk("post_rst_state", pad_state, 4'b0111);
        chk("post_rst_pulse", press_pulse, 4'b0111);
        tick();
        chk("post_rst_evt_press", evt_press, 4'b0111);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;

        // Release of pad 1
        pad_event(4'b0101, 1'b0);
        chk("release_state", pad_state, 4'b0101);
`ifdef PAD_RELEASE_EVT_EN
        chk("release_valid", evt_valid, 1'b1);
        chk("release_evt_press", evt_press, 4'b0000);
        chk("release_evt_release", evt_release, 4'b0010);
`else
        chk("release_no_push", evt_valid, 1'b0);
        chk("release_evt_release", evt_release, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_pad_receiver.md
Name: ddr_pad_receiver

Overview:
- Input-side counterpart to the buzzer output driver: takes raw dance-pad switch lines in and produces clean, debounced step information for game logic.
- Per-pad path: 2-flop synchronizer, then counter-based debouncer, then rising-edge press detector.
- Press masks are buffered in a small event FIFO with a valid/ready pop interface, so the scoring FSM never misses a step while it is busy.

Parameters:
N_PADS, 4, number of pad inputs (left/down/up/right)
DEBOUNCE_CYCLES, 50000, consecutive cycles of disagreement required before the debounced state changes (1 ms at 50 MHz); minimum 2
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pad_raw  input  N_PADS  raw asynchronous pad switch levels, 1 = pressed
pad_state  output  N_PADS  debounced pad levels
press_pulse  output  N_PADS  one-cycle strobe per pad on debounced 0->1
evt_valid  output  1  FIFO non-empty
evt_ready  input  1  consumer accepts head entry when evt_valid=1
evt_press  output  N_PADS  head entry press mask
evt_release  output  N_PADS  head entry release mask (0 without PAD_RELEASE_EVT_EN)
evt_overflow  output  1  sticky: an event was dropped because the FIFO was full
clr_overflow  input  1  synchronous clear of evt_overflow

Behaviour:
- Reset: asserting rst asynchronously clears synchronizer flops, debounce counters, pad_state, press_pulse, FIFO pointers/count, evt_overflow. Output values during and after reset: evt_valid=0, evt_press=0, evt_release=0.
- Reset mid-operation discards queued events and any partial debounce count.
- Synchronizer: sync1<=pad_raw, sync2<=sync1 per bit. No logic between the two stages.
- Debounce, per pad, using cnt and stable (stable drives pad_state):
  - sync2==stable: cnt<=0.
  - sync2!=stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0.
  - Any glitch back to agreement restarts the count from 0.
- Latency: a clean pad_raw step sampled at edge k appears on pad_state at edge k+1+DEBOUNCE_CYCLES (2 edges of sync, DEBOUNCE_CYCLES of count, overlapping by one).
- press_pulse[i] is registered. It is 1 for exactly the cycle in which pad_state[i] first reads 1 after having been 0. Several bits may pulse in the same cycle.
- FIFO push: push occurs when |press_pulse is 1, or (with the feature) when any release strobe is 1. One entry per cycle holds the full masks, so simultaneous presses share one entry.
- Pushed entry visibility: it becomes visible on evt_* one cycle after the strobe cycle if the FIFO was empty.
- Pop: a pop occurs on an edge where evt_valid & evt_ready. Head outputs are registered/stable while evt_valid=1 and no pop occurs.
- Full and push without pop: the entry is dropped and evt_overflow<=1. Stored contents are unchanged.
- Full and push with pop in the same cycle: both are performed, no overflow, count unchanged.
- Empty and pop attempt: ignored (evt_valid=0). Pointers wrap modulo FIFO_DEPTH.
- clr_overflow and a new overflow in the same cycle: the set wins.
- Count width: log2(FIFO_DEPTH)+1 bits. evt_valid = (count!=0).

Optional Feature:
- Macro: PAD_RELEASE_EVT_EN.
- Defined: each pad also generates a one-cycle release strobe on debounced 1->0.
  - An entry is pushed if any press or release strobe is set; evt_release carries the release mask.
  - Press and release on different pads in one cycle share one entry.
- Undefined: no release logic is generated, evt_release is tied to 0, and releases never push.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Clean press: pad_raw[0] 0->1 held, sampled at edge k -> pad_state[0]=1 and press_pulse[0]=1 for exactly 1 cycle at edge k+5; next cycle evt_valid=1, evt_press=4'b0001; pop with evt_ready=1 -> evt_valid=0.
- Bounce: pad_raw[2] toggles every 2 cycles for 20 cycles, then held 1 -> no pulse during the toggling; a single press_pulse[2] 5 cycles after the final hold; exactly one FIFO entry.
- Simultaneous: pad_raw=4'b1010 on the same edge -> one entry with evt_press=4'b1010, press_pulse=4'b1010 for one cycle.
- Overflow: evt_ready=0, 5 separate debounced presses -> entries 1-4 are retained in order, the 5th is dropped, evt_overflow=1.
  - Full with simultaneous push+pop -> no overflow.
  - clr_overflow -> evt_overflow=0.
- Reset mid-count: rst asserted at cnt=2 with 2 entries queued, asynchronously between edges -> all outputs 0 immediately; after release, raw=1 held gives a fresh full 5-cycle latency.
- Release (with PAD_RELEASE_EVT_EN): press pad 1, pop, release -> entry evt_press=0, evt_release=4'b0010.
  - Without the macro, the release pushes nothing and evt_release stays 0.
